clk_div_gate_ctrl: RTL and testbench



---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_gate_ctrl.sv | 148 ++++++++++++++
 tb/tb_clk_div_gate_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and width helpers for the divided-clock gate controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        RUNNING  = 2'd0,
        STOPPING = 2'd1,
        OFF      = 2'd2,
        STARTING = 2'd3
    } clk_div_state_e;

    // Low-run counter must be able to hold DIV/2+1 without wrapping.
    function automatic int low_cnt_width(input int div);
        return $clog2(div) + 1;
    endfunction

    function automatic int tmo_cnt_width(input int div, input int mult);
        return $clog2(mult * div) + 1;
    endfunction

endpackage

// File: rtl/clk_div_gate_ctrl.sv
// Drives divclk_sel of a power-of-2 divider and confirms, from the divider MSB,
// that the divided clock has really started or parked low.
module clk_div_gate_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV      = 64,
    parameter int TMO_MULT = 3
) (
    input  logic refclk,
    input  logic rstn,
    input  logic req_valid,
    input  logic req_on,
    output logic req_ready,
    output logic divclk_sel,
    input  logic div_msb,
    output logic done,
    output logic running,
    output logic busy,
    output logic err
);

    localparam int LOW_W = low_cnt_width(DIV);
    localparam int TMO_W = tmo_cnt_width(DIV, TMO_MULT);
    // Last counter values before the low-run / timeout limits are reached.
    localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(DIV / 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MULT * DIV - 1);

    if (DIV < 4 || (DIV & (DIV - 1)) != 0) begin : g_bad_div
        $fatal(1, "clk_div_gate_ctrl: DIV must be a power of 2 and at least 4");
    end

    clk_div_state_e   r_state;
    clk_div_state_e   w_next_state;
    logic             r_msb_q;
    logic [LOW_W-1:0] r_low_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_done;
    logic             r_running;
    logic             r_err;
    logic             r_ack_pend;

    logic w_accept;
    logic w_redundant;
    logic w_rise;
    logic w_low_hit;
    logic w_tmo_hit;
    logic w_complete;
    logic w_finish;

    assign w_accept    = req_valid & req_ready;
    assign w_redundant = w_accept & (req_on == (r_state == RUNNING));
    assign w_rise      = div_msb & ~r_msb_q;
    // Low for DIV/2+1 cycles is longer than any half-period of a running divider.
    assign w_low_hit   = (r_state == STOPPING) & ~r_msb_q & (r_low_cnt == LOW_LAST);
    assign w_tmo_hit   = busy & (r_tmo_cnt == TMO_LAST);
    assign w_complete  = w_low_hit | ((r_state == STARTING) & w_rise);
    assign w_finish    = busy & (w_complete | w_tmo_hit);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge refclk) begin
        if (!rstn) begin
            r_state <= RUNNING;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default first so no path through the case leaves w_next_state unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            RUNNING:  if (w_accept && !req_on)      w_next_state = STOPPING;
            STOPPING: if (w_low_hit || w_tmo_hit)   w_next_state = OFF;
            OFF:      if (w_accept && req_on)       w_next_state = STARTING;
            STARTING: if (w_rise || w_tmo_hit)      w_next_state = RUNNING;
            default:                                w_next_state = RUNNING;
        endcase
    end

    always_comb begin
        divclk_sel = 1'b0;
        req_ready  = 1'b0;
        busy       = 1'b0;
        unique case (r_state)
            RUNNING: begin
                divclk_sel = 1'b1;
                req_ready  = 1'b1;
            end
            STOPPING: begin
                busy = 1'b1;
            end
            OFF: begin
                req_ready = 1'b1;
            end
            STARTING: begin
                divclk_sel = 1'b1;
                busy       = 1'b1;
            end
            default: begin
                divclk_sel = 1'b1;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (!rstn) begin
            r_msb_q    <= 1'b0;
            r_low_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_done     <= 1'b0;
            r_running  <= 1'b1;
            r_err      <= 1'b0;
            r_ack_pend <= 1'b0;
        end else begin
            r_msb_q    <= div_msb;
            // A request for the current state is acknowledged one cycle after acceptance.
            r_ack_pend <= w_redundant;
            r_done     <= r_ack_pend | w_finish;

            if (w_accept) begin
                r_low_cnt <= '0;
                r_tmo_cnt <= '0;
                r_err     <= 1'b0;
            end else if (busy) begin
                if (r_tmo_cnt != '1) begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                end
                if (r_msb_q) begin
                    r_low_cnt <= '0;
                end else if (r_low_cnt != '1) begin
                    r_low_cnt <= r_low_cnt + LOW_W'(1);
                end
            end

            if (w_finish) begin
                r_running <= (r_state == STARTING);
                if (!w_complete) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign done    = r_done;
    assign running = r_running;
    assign err     = r_err;

endmodule

// File: tb/tb_clk_div_gate_ctrl.sv
// Bench for clk_div_gate_ctrl driving a behavioural power-of-2 divider (DIV=8),
// with a request-level reference model compared every cycle.
module tb_clk_div_gate_ctrl;

    localparam int DIV      = 8;
    localparam int TMO_MULT = 3;
    localparam int TMO      = TMO_MULT * DIV;

    logic refclk;
    logic rstn;
    logic req_valid;
    logic req_on;
    logic req_ready;
    logic divclk_sel;
    logic div_msb;
    logic done;
    logic running;
    logic busy;
    logic err;

    logic [2:0] div_cnt;
    logic       stuck;

    int n_tests;
    int n_fail;

    clk_div_gate_ctrl #(
        .DIV      (DIV),
        .TMO_MULT (TMO_MULT)
    ) dut (
        .refclk     (refclk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_on     (req_on),
        .req_ready  (req_ready),
        .divclk_sel (divclk_sel),
        .div_msb    (div_msb),
        .done       (done),
        .running    (running),
        .busy       (busy),
        .err        (err)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // The controlled divider: counts while selected, otherwise finishes its period and parks at 0.
    always @(posedge refclk) begin
        if (!rstn) begin
            div_cnt <= 3'd0;
        end else if (divclk_sel || div_cnt != 3'd0) begin
            div_cnt <= div_cnt + 3'd1;
        end
    end
    assign div_msb = stuck | div_cnt[2];

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_n(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: confirmed level, whether a transition is pending, and the MSB samples
    // seen since the request was accepted.
    logic m_level;
    logic m_moving;
    logic m_err;
    logic m_done;
    logic m_pend;
    int   m_n;
    logic m_hist[$];

    function automatic logic last_all_low(input int need);
        if (m_hist.size() < need) return 1'b0;
        for (int k = 0; k < need; k++) begin
            if (m_hist[m_hist.size() - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        logic d;
        logic fin;
        if (!rstn) begin
            m_level  = 1'b1;
            m_moving = 1'b0;
            m_err    = 1'b0;
            m_done   = 1'b0;
            m_pend   = 1'b0;
            m_hist.delete();
        end else begin
            d      = m_pend;
            m_pend = 1'b0;
            if (!m_moving) begin
                if (req_valid) begin
                    m_err = 1'b0;
                    if (req_on == m_level) begin
                        m_pend = 1'b1;
                    end else begin
                        m_moving = 1'b1;
                        m_n      = 0;
                        m_hist.delete();
                        m_hist.push_back(div_msb);
                    end
                end
            end else begin
                m_n++;
                if (m_level) fin = last_all_low(DIV / 2 + 1);
                else         fin = div_msb && !m_hist[m_hist.size() - 1];
                if (!fin && m_n == TMO) begin
                    fin   = 1'b1;
                    m_err = 1'b1;
                end
                if (fin) begin
                    m_level  = !m_level;
                    m_moving = 1'b0;
                    d        = 1'b1;
                end else begin
                    m_hist.push_back(div_msb);
                end
            end
            m_done = d;
        end
    endtask

    initial forever begin
        @(posedge refclk);
        model_step();
    end

    logic cmp_en;
    initial forever begin
        @(negedge refclk);
        if (cmp_en) begin
            check("cmp_ready",   req_ready,  !m_moving);
            check("cmp_busy",    busy,       m_moving);
            check("cmp_sel",     divclk_sel, m_moving ? !m_level : m_level);
            check("cmp_running", running,    m_level);
            check("cmp_done",    done,       m_done);
            check("cmp_err",     err,        m_err);
        end
    end

    logic watch_en;
    logic saw_drop;
    logic saw_busy;
    initial forever begin
        @(negedge refclk);
        if (watch_en) begin
            if (!divclk_sel) saw_drop = 1'b1;
            if (busy)        saw_busy = 1'b1;
        end
    end

    task automatic measure_period(output int p);
        logic prev;
        int   guard;
        p     = 0;
        guard = 0;
        prev  = div_msb;
        while (guard < 40 && !(div_msb && !prev)) begin
            prev = div_msb;
            @(negedge refclk);
            guard++;
        end
        prev = div_msb;
        @(negedge refclk);
        p = 1;
        while (p < 40 && !(div_msb && !prev)) begin
            prev = div_msb;
            @(negedge refclk);
            p++;
        end
    endtask

    task automatic do_req(input logic on, output int lat, output int rise, output logic sel0);
        int guard;
        guard     = 0;
        req_valid = 1'b1;
        req_on    = on;
        while (!req_ready && guard < 100) begin
            @(negedge refclk);
            guard++;
        end
        check("req_ready_seen", req_ready, 1'b1);
        @(negedge refclk);
        req_valid = 1'b0;
        sel0      = divclk_sel;
        rise      = -1;
        lat       = 0;
        while (lat < 100) begin
            if (rise < 0 && div_msb) rise = lat;
            if (done) break;
            @(negedge refclk);
            lat++;
        end
    endtask

    int   lat;
    int   rise;
    int   per;
    logic sel0;
    logic bad;
    int   n_done;
    int   first_done;
    int   guard;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_on    = 1'b0;
        stuck     = 1'b0;
        cmp_en    = 1'b0;
        watch_en  = 1'b0;
        saw_drop  = 1'b0;
        saw_busy  = 1'b0;

        @(posedge refclk);
        @(negedge refclk);
        cmp_en = 1'b1;
        check("rst_running", running,    1'b1);
        check("rst_sel",     divclk_sel, 1'b1);
        check("rst_ready",   req_ready,  1'b1);
        check("rst_busy",    busy,       1'b0);
        check("rst_done",    done,       1'b0);
        check("rst_err",     err,        1'b0);
        @(negedge refclk);
        rstn = 1'b1;
        measure_period(per);
        check_n("period_after_reset", per, 8);

        // Stop requested while the divider count is 0.
        guard = 0;
        while (div_cnt != 3'd0 && guard < 20) begin
            @(negedge refclk);
            guard++;
        end
        do_req(1'b0, lat, rise, sel0);
        check("stop_sel_drop", sel0, 1'b0);
        check_n("stop_latency", lat, 13);
        check("stop_running", running, 1'b0);
        check("stop_err", err, 1'b0);
        bad = 1'b0;
        repeat (100) begin
            @(negedge refclk);
            if (div_msb) bad = 1'b1;
        end
        check("parked_low_100", bad, 1'b0);

        do_req(1'b0, lat, rise, sel0);
        check_n("redundant_off_latency", lat, 1);
        check("redundant_off_running", running, 1'b0);

        do_req(1'b1, lat, rise, sel0);
        check("start_sel_rise", sel0, 1'b1);
        check_n("start_msb_rise", rise, 4);
        check_n("start_latency", lat, 5);
        check("start_running", running, 1'b1);
        measure_period(per);
        check_n("period_after_start", per, 8);

        watch_en = 1'b1;
        do_req(1'b1, lat, rise, sel0);
        repeat (3) @(negedge refclk);
        watch_en = 1'b0;
        check_n("redundant_on_latency", lat, 1);
        check("redundant_on_no_sel_drop", saw_drop, 1'b0);
        check("redundant_on_no_busy", saw_busy, 1'b0);

        // Divider output stuck high: the stop must time out.
        stuck = 1'b1;
        do_req(1'b0, lat, rise, sel0);
        check_n("stuck_timeout_latency", lat, 24);
        check("stuck_err", err, 1'b1);
        check("stuck_running", running, 1'b0);
        check("stuck_ready", req_ready, 1'b1);
        check("stuck_sel", divclk_sel, 1'b0);
        stuck = 1'b0;
        @(negedge refclk);

        do_req(1'b1, lat, rise, sel0);
        check("restart_err_cleared", err, 1'b0);
        check_n("restart_latency", lat, 5);
        check("restart_running", running, 1'b1);

        // Reset in the middle of a stop while a new request is held.
        req_valid = 1'b1;
        req_on    = 1'b0;
        @(negedge refclk);
        req_on = 1'b1;
        check("held_busy", busy, 1'b1);
        repeat (3) @(negedge refclk);
        check("held_not_ready", req_ready, 1'b0);
        rstn = 1'b0;
        @(negedge refclk);
        check("midrst_sel", divclk_sel, 1'b1);
        check("midrst_running", running, 1'b1);
        check("midrst_err", err, 1'b0);
        check("midrst_ready", req_ready, 1'b1);
        rstn = 1'b1;
        @(negedge refclk);
        req_valid  = 1'b0;
        n_done     = 0;
        first_done = -1;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
            @(negedge refclk);
        end
        check_n("held_done_count", n_done, 1);
        check_n("held_done_delay", first_done, 1);
        check("held_final_sel", divclk_sel, 1'b1);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

endmodule
